// File: rtl/midi_pkg.sv
// Shared constants and parser state type for the MIDI gate controller.
package midi_pkg;
    localparam logic [3:0] NOTE_OFF  = 4'h8;
    localparam logic [3:0] NOTE_ON   = 4'h9;
    localparam logic [7:0] RT_THRESH = 8'hF8;

    typedef enum logic [1:0] {
        WAIT_STATUS = 2'd0,
        WAIT_D1     = 2'd1,
        WAIT_D2     = 2'd2
    } parse_state_t;
endpackage

// File: rtl/note_stack.sv
// Last-note-priority key stack: index 0 is the oldest entry, count-1 the top.
module note_stack #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       remove,
    input  logic [6:0] key,
    input  logic [6:0] vel,
    output logic [6:0] top_key,
    output logic [6:0] top_vel,
    output logic [4:0] count,
    output logic       empty
);
    logic [6:0] keys  [DEPTH];
    logic [6:0] vels  [DEPTH];
    logic [6:0] nkeys [DEPTH];
    logic [6:0] nvels [DEPTH];
    logic [4:0] ncount;
    logic [4:0] hit_idx;
    logic [4:0] rm_idx;
    logic       hit;
    logic       do_rm;

    always_comb begin
        nkeys   = keys;
        nvels   = vels;
        ncount  = count;
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i < 32'(count) && keys[i] == key) begin
                hit     = 1'b1;
                hit_idx = 5'(i);
            end
        end
        // A matching key is removed before re-push; a full stack without a match loses entry 0.
        do_rm  = ((push || remove) && hit) || (push && !hit && count == 5'(DEPTH));
        rm_idx = hit ? hit_idx : '0;
        if (do_rm) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                if (i >= 32'(rm_idx)) begin
                    nkeys[i] = keys[i + 1];
                    nvels[i] = vels[i + 1];
                end
            end
            ncount = count - 5'd1;
        end
        if (push) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (i == 32'(ncount)) begin
                    nkeys[i] = key;
                    nvels[i] = vel;
                end
            end
            ncount = ncount + 5'd1;
        end
    end

    always_comb begin
        top_key = '0;
        top_vel = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i + 1 == 32'(count)) begin
                top_key = keys[i];
                top_vel = vels[i];
            end
        end
        empty = (count == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                keys[i] <= '0;
                vels[i] <= '0;
            end
        end else begin
            count <= ncount;
            keys  <= nkeys;
            vels  <= nvels;
        end
    end
endmodule

// File: rtl/midi_gate_ctrl.sv
// MIDI note-on/off parser for one channel driving GATE/note/velocity with a
// timed retrigger gap so the envelope restarts its attack on a new note.
module midi_gate_ctrl
    import midi_pkg::*;
#(
    parameter int CHANNEL      = 0,
    parameter int DEPTH        = 8,
    parameter int RETRIG_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] midi_byte,
    input  logic       midi_valid,
    output logic       gate,
    output logic [6:0] note,
    output logic [6:0] velocity,
    output logic [4:0] note_count,
    output logic       retrig
);
    parse_state_t state;
    logic         run_on;
    logic [6:0]   key_l;
    logic         is_rt, is_status, is_data, ch_match;
    logic         complete, msg_on, msg_off;
    logic         on_evt;
    logic [7:0]   gap_cnt;
    logic [6:0]   st_key, st_vel;
    logic [4:0]   st_count;
    logic         st_empty;

    always_comb begin
        is_rt     = (midi_byte >= RT_THRESH);
        is_status = midi_byte[7] && !is_rt;
        is_data   = !midi_byte[7];
        ch_match  = (midi_byte[7:4] == NOTE_OFF || midi_byte[7:4] == NOTE_ON)
                    && (midi_byte[3:0] == 4'(CHANNEL));
        complete  = midi_valid && is_data && (state == WAIT_D2);
        msg_on    = complete && run_on && (midi_byte[6:0] != '0);
        msg_off   = complete && !(run_on && (midi_byte[6:0] != '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= WAIT_STATUS;
            run_on <= 1'b0;
            key_l  <= '0;
        end else if (midi_valid) begin
            if (is_status) begin
                if (ch_match) begin
                    state  <= WAIT_D1;
                    run_on <= (midi_byte[7:4] == NOTE_ON);
                end else begin
                    state  <= WAIT_STATUS;
                    run_on <= 1'b0;
                end
            end else if (is_data) begin
                case (state)
                    WAIT_D1: begin
                        key_l <= midi_byte[6:0];
                        state <= WAIT_D2;
                    end
                    WAIT_D2: state <= WAIT_D1;
                    default: ;
                endcase
            end
        end
    end

    note_stack #(.DEPTH(DEPTH)) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (msg_on),
        .remove  (msg_off),
        .key     (key_l),
        .vel     (midi_byte[6:0]),
        .top_key (st_key),
        .top_vel (st_vel),
        .count   (st_count),
        .empty   (st_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_evt     <= 1'b0;
            gate       <= 1'b0;
            note       <= '0;
            velocity   <= '0;
            note_count <= '0;
            retrig     <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            on_evt     <= msg_on;
            retrig     <= 1'b0;
            note_count <= st_count;
            if (!st_empty) begin
                note     <= st_key;
                velocity <= st_vel;
            end
            // Reload takes priority over an ena decrement arriving in the same cycle.
            if (st_empty) begin
                gate    <= 1'b0;
                gap_cnt <= '0;
            end else if (on_evt && RETRIG_TICKS > 0 && (gate || gap_cnt != '0)) begin
                gate    <= 1'b0;
                retrig  <= 1'b1;
                gap_cnt <= 8'(RETRIG_TICKS);
            end else if (gap_cnt != '0) begin
                if (ena) begin
                    gap_cnt <= gap_cnt - 8'd1;
                    if (gap_cnt == 8'd1) gate <= 1'b1;
                end
            end else begin
                gate <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_midi_gate_ctrl.sv
// Self-checking bench for midi_gate_ctrl: directed scenarios plus randomized
// message streams compared against a queue-based last-note-priority model.
module tb_midi_gate_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] midi_byte;
    logic       midi_valid;
    logic       gate;
    logic [6:0] note;
    logic [6:0] velocity;
    logic [4:0] note_count;
    logic       retrig;

    int checks = 0;
    int failures = 0;
    int retrig_seen = 0;
    int gate_low_seen = 0;

    logic [6:0] mkeys[$];
    logic [6:0] mvels[$];
    logic [6:0] m_note, m_vel;

    midi_gate_ctrl #(.CHANNEL(0), .DEPTH(8), .RETRIG_TICKS(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .midi_byte  (midi_byte),
        .midi_valid (midi_valid),
        .gate       (gate),
        .note       (note),
        .velocity   (velocity),
        .note_count (note_count),
        .retrig     (retrig)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (retrig === 1'b1) retrig_seen++;
        if (gate !== 1'b1) gate_low_seen++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    function automatic void m_clear();
        mkeys.delete();
        mvels.delete();
        m_note = '0;
        m_vel  = '0;
    endfunction

    function automatic void m_on(input logic [6:0] k, input logic [6:0] v);
        for (int i = 0; i < mkeys.size(); i++) begin
            if (mkeys[i] == k) begin
                mkeys.delete(i);
                mvels.delete(i);
                break;
            end
        end
        if (mkeys.size() == 8) begin
            mkeys.delete(0);
            mvels.delete(0);
        end
        mkeys.push_back(k);
        mvels.push_back(v);
        m_note = k;
        m_vel  = v;
    endfunction

    function automatic void m_off(input logic [6:0] k);
        for (int i = 0; i < mkeys.size(); i++) begin
            if (mkeys[i] == k) begin
                mkeys.delete(i);
                mvels.delete(i);
                break;
            end
        end
        if (mkeys.size() > 0) begin
            m_note = mkeys[mkeys.size() - 1];
            m_vel  = mvels[mvels.size() - 1];
        end
    endfunction

    // Each step drives inputs just after a negedge and returns at the next negedge.
    task automatic step(input logic v, input logic [7:0] b, input logic e);
        midi_valid = v;
        midi_byte  = b;
        ena        = e;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n, input logic e);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2, 1'b0);
        checks++;
        if ({gate, note, velocity, note_count, retrig} !== 21'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required %h",
                     {gate, note, velocity, note_count, retrig}, 21'h0);
        end
        rst_n = 1'b1;
        idle(1, 1'b0);
        m_clear();
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_single_note();
        do_reset();
        send(8'h90); send(8'h3C); send(8'h64);
        checks++;
        if ({gate, note_count} !== {1'b0, 5'd0}) begin
            failures++;
            $display("FAIL single_latency_early: got %h required %h", {gate, note_count}, 6'h00);
        end
        idle(1, 1'b0);
        checks++;
        if ({gate, note, velocity, note_count} !== {1'b1, 7'h3C, 7'h64, 5'd1}) begin
            failures++;
            $display("FAIL single_on: got %h required %h",
                     {gate, note, velocity, note_count}, {1'b1, 7'h3C, 7'h64, 5'd1});
        end
        send(8'h80); send(8'h3C); send(8'h00);
        idle(1, 1'b0);
        checks++;
        if ({gate, note, velocity, note_count} !== {1'b0, 7'h3C, 7'h64, 5'd0}) begin
            failures++;
            $display("FAIL single_off: got %h required %h",
                     {gate, note, velocity, note_count}, {1'b0, 7'h3C, 7'h64, 5'd0});
        end
    endtask

    task automatic test_running_status();
        int r0;
        int ticks;
        do_reset();
        send(8'h90); send(8'h40); send(8'h50);
        idle(3, 1'b0);
        checks++;
        if ({gate, note} !== {1'b1, 7'h40}) begin
            failures++;
            $display("FAIL rs_first: got %h required %h", {gate, note}, {1'b1, 7'h40});
        end
        r0 = retrig_seen;
        send(8'h43); send(8'h50);
        idle(1, 1'b0);
        checks++;
        if ({gate, retrig, note} !== {1'b0, 1'b1, 7'h43}) begin
            failures++;
            $display("FAIL rs_retrig_start: got %h required %h", {gate, retrig, note}, {1'b0, 1'b1, 7'h43});
        end
        ticks = 0;
        for (int n = 0; n < 20; n++) begin
            step(1'b0, 8'h00, 1'b1);
            ticks++;
            if (gate === 1'b1) break;
            step(1'b0, 8'h00, 1'b0);
            if (gate === 1'b1) break;
        end
        checks++;
        if ({gate, ticks} !== {1'b1, 32'd2}) begin
            failures++;
            $display("FAIL rs_gap_ticks: got gate=%b ticks=%0d required gate=1 ticks=2", gate, ticks);
        end
        checks++;
        if (retrig_seen - r0 !== 1) begin
            failures++;
            $display("FAIL rs_retrig_count: got %0d required 1", retrig_seen - r0);
        end
        send(8'h40); send(8'h00);
        idle(2, 1'b0);
        checks++;
        if ({gate, note, note_count} !== {1'b1, 7'h43, 5'd1}) begin
            failures++;
            $display("FAIL rs_off_other: got %h required %h", {gate, note, note_count}, {1'b1, 7'h43, 5'd1});
        end
    endtask

    task automatic test_legato();
        int r0;
        int g0;
        do_reset();
        send(8'h90); send(8'h30); send(8'h7F); send(8'h34); send(8'h7F);
        idle(6, 1'b1);
        r0 = retrig_seen;
        g0 = gate_low_seen;
        send(8'h80); send(8'h34); send(8'h00);
        idle(4, 1'b1);
        checks++;
        if ({gate, note, velocity, note_count} !== {1'b1, 7'h30, 7'h7F, 5'd1}) begin
            failures++;
            $display("FAIL legato_top: got %h required %h",
                     {gate, note, velocity, note_count}, {1'b1, 7'h30, 7'h7F, 5'd1});
        end
        checks++;
        if ({retrig_seen - r0, gate_low_seen - g0} !== {32'd0, 32'd0}) begin
            failures++;
            $display("FAIL legato_no_gap: got retrigs=%0d low_cycles=%0d required 0 0",
                     retrig_seen - r0, gate_low_seen - g0);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send(8'h90);
        for (int k = 8'h20; k <= 8'h28; k++) begin
            send(8'(k)); send(8'h40);
        end
        idle(4, 1'b1);
        checks++;
        if ({note_count, note} !== {5'd8, 7'h28}) begin
            failures++;
            $display("FAIL overflow_full: got %h required %h", {note_count, note}, {5'd8, 7'h28});
        end
        send(8'h80);
        for (int k = 8'h21; k <= 8'h28; k++) begin
            send(8'(k)); send(8'h00);
        end
        idle(2, 1'b0);
        checks++;
        if ({gate, note_count} !== {1'b0, 5'd0}) begin
            failures++;
            $display("FAIL overflow_drained: got %h required %h", {gate, note_count}, {1'b0, 5'd0});
        end
    endtask

    task automatic test_filtering();
        do_reset();
        send(8'h90); send(8'hF8); send(8'h3C); send(8'hF8); send(8'h64);
        idle(1, 1'b0);
        checks++;
        if ({gate, note, velocity, note_count} !== {1'b1, 7'h3C, 7'h64, 5'd1}) begin
            failures++;
            $display("FAIL filter_realtime: got %h required %h",
                     {gate, note, velocity, note_count}, {1'b1, 7'h3C, 7'h64, 5'd1});
        end
        send(8'h81); send(8'h3C); send(8'h00);
        send(8'h91); send(8'h55); send(8'h64);
        idle(6, 1'b1);
        checks++;
        if ({gate, note, note_count} !== {1'b1, 7'h3C, 5'd1}) begin
            failures++;
            $display("FAIL filter_channel: got %h required %h", {gate, note, note_count}, {1'b1, 7'h3C, 5'd1});
        end
        send(8'h90); send(8'h3C); send(8'h64);
        idle(6, 1'b1);
        send(8'hB0); send(8'h07); send(8'h7F); send(8'h3C); send(8'h00);
        idle(4, 1'b1);
        checks++;
        if ({gate, note, note_count} !== {1'b1, 7'h3C, 5'd1}) begin
            failures++;
            $display("FAIL filter_other_status: got %h required %h", {gate, note, note_count}, {1'b1, 7'h3C, 5'd1});
        end
    endtask

    task automatic test_reset_mid_message();
        do_reset();
        send(8'h90); send(8'h3C);
        do_reset();
        send(8'h3C); send(8'h64);
        idle(3, 1'b0);
        checks++;
        if ({gate, note_count, note} !== {1'b0, 5'd0, 7'h00}) begin
            failures++;
            $display("FAIL reset_mid_msg: got %h required %h", {gate, note_count, note}, 13'h0);
        end
    endtask

    task automatic test_random();
        logic [7:0] cur_status;
        logic [7:0] st;
        logic [6:0] k, v;
        logic       is_on, exp_rt;
        int         r0, r;
        do_reset();
        cur_status = 8'h00;
        for (int m = 0; m < 60; m++) begin
            r = int'($urandom_range(9, 0));
            k = 7'(8'h30 + $urandom_range(9, 0));
            v = 7'($urandom_range(127, 1));
            if (r < 6) begin
                st = 8'h90;
            end else if (r < 8) begin
                st = 8'h80;
                if (mkeys.size() > 0 && $urandom_range(1, 0) == 1)
                    k = mkeys[$urandom_range(mkeys.size() - 1, 0)];
                v = 7'($urandom_range(127, 0));
            end else begin
                st = 8'h90;
                v  = 7'h00;
                if (mkeys.size() > 0)
                    k = mkeys[$urandom_range(mkeys.size() - 1, 0)];
            end
            is_on  = (st == 8'h90) && (v != 0);
            exp_rt = is_on && (mkeys.size() > 0);
            if (is_on) m_on(k, v);
            else m_off(k);
            r0 = retrig_seen;
            if (st != cur_status || $urandom_range(1, 0) == 1) begin
                send(st);
                if ($urandom_range(3, 0) == 0) send(8'(8'hF8 + $urandom_range(7, 0)));
            end
            cur_status = st;
            send({1'b0, k});
            if ($urandom_range(3, 0) == 0) send(8'hF8);
            send({1'b0, v});
            idle(6, 1'b1);
            checks++;
            if ({gate, note, velocity, note_count} !==
                {mkeys.size() > 0, m_note, m_vel, 5'(mkeys.size())}) begin
                failures++;
                $display("FAIL random_state[%0d]: got %h required %h", m,
                         {gate, note, velocity, note_count},
                         {mkeys.size() > 0, m_note, m_vel, 5'(mkeys.size())});
            end
            checks++;
            if (retrig_seen - r0 !== (exp_rt ? 1 : 0)) begin
                failures++;
                $display("FAIL random_retrig[%0d]: got %0d required %0d", m,
                         retrig_seen - r0, exp_rt ? 1 : 0);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b0;
        midi_valid = 1'b0;
        midi_byte  = 8'h00;
        m_clear();
        @(negedge clk);
        test_reset();
        test_single_note();
        test_running_status();
        test_legato();
        test_overflow();
        test_filtering();
        test_reset_mid_message();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
